// File: rtl/cga_pkg.sv
// rtl/cga_pkg.sv - pixel depth encodings and per-depth helper functions
package cga_pkg;

  typedef enum logic [1:0] {
    BPP_1    = 2'd0,
    BPP_2    = 2'd1,
    BPP_4    = 2'd2,
    BPP_RSVD = 2'd3
  } bpp_e;

  // The reserved encoding behaves as 1 bpp.
  function automatic int bpp_bits(logic [1:0] bpp);
    case (bpp_e'(bpp))
      BPP_2:   return 2;
      BPP_4:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int pix_per_word(logic [1:0] bpp, int data_w);
    return data_w / bpp_bits(bpp);
  endfunction

endpackage

// File: rtl/cga_pix_fifo.sv
// rtl/cga_pix_fifo.sv - fetch-word FIFO with flush; a push in the flush cycle lands in the emptied FIFO
module cga_pix_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              flush_i,
  input  logic                              push_i,
  input  logic [DATA_W-1:0]                 push_data_i,
  input  logic                              pop_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic [DATA_W-1:0]                 head_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_idx;

  assign wr_idx  = flush_i ? '0 : wr_ptr_q;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = push_i ? AW'(1) : '0;
      count_d  = push_i ? CW'(1) : '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/cga_pixel_shifter.sv
// rtl/cga_pixel_shifter.sv - packed-pixel serializer with dot divider, display-enable delay and underrun flag
module cga_pixel_shifter
  import cga_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int PIX_W      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int DE_DELAY   = 2
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [1:0]        bpp_i,
  input  logic [1:0]        dot_div_i,
  input  logic              video_enabled_i,
  input  logic              line_start_i,
  input  logic [DATA_W-1:0] fetch_data_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic              display_enable_i,
  output logic [PIX_W-1:0]  pix_out_o,
  output logic              pix_de_o,
  output logic              underrun_o
);

  localparam int RW = $clog2(DATA_W + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  function automatic logic [3:0] top_pixel(logic [DATA_W-1:0] w, logic [1:0] b);
    case (bpp_bits(b))
      4:       top_pixel = w[DATA_W-1 -: 4];
      2:       top_pixel = {2'b00, w[DATA_W-1 -: 2]};
      default: top_pixel = {3'b000, w[DATA_W-1]};
    endcase
  endfunction

  logic                run_q;
  logic [DE_DELAY-1:0] de_sr_q;
  logic                pix_de_q;
  logic [1:0]          div_q, div_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [RW-1:0]       rem_q, rem_d;
  logic [1:0]          bpp_lat_q, bpp_lat_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                underrun_q, underrun_d;

  logic                de_d, tick, fetch_accept, fifo_pop, have_pix;
  logic [CW-1:0]       fifo_count;
  logic [DATA_W-1:0]   fifo_head, word;
  logic [1:0]          bits_sel;

  assign de_d          = de_sr_q[DE_DELAY-1];
  assign tick          = de_d && (div_q == dot_div_i);
  assign fetch_ready_o = run_q && (fifo_count < CW'(FIFO_DEPTH));
  assign fetch_accept  = fetch_valid_i && fetch_ready_o;
  assign pix_out_o     = pix_q;
  assign pix_de_o      = pix_de_q;
  assign underrun_o    = underrun_q;

  cga_pix_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (line_start_i),
    .push_i      (fetch_accept),
    .push_data_i (fetch_data_i),
    .pop_i       (fifo_pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  always_comb begin
    div_d = '0;
    if (de_d) div_d = (div_q == dot_div_i) ? 2'd0 : div_q + 2'd1;
    shreg_d    = shreg_q;
    rem_d      = rem_q;
    bpp_lat_d  = bpp_lat_q;
    pix_d      = pix_q;
    underrun_d = underrun_q;
    fifo_pop   = 1'b0;
    have_pix   = 1'b0;
    word       = shreg_q;
    bits_sel   = bpp_lat_q;
    if (line_start_i) begin
      shreg_d    = '0;
      rem_d      = '0;
      div_d      = '0;
      underrun_d = 1'b0;
    end else if (tick) begin
      if (rem_q != '0) begin
        rem_d    = rem_q - RW'(1);
        have_pix = 1'b1;
      end else if (fifo_count == '0) begin
        pix_d      = '0;
        underrun_d = 1'b1;
      end else begin
        // Word load: the first pixel of the new word goes out on this same tick.
        fifo_pop  = 1'b1;
        word      = fifo_head;
        bits_sel  = bpp_i;
        bpp_lat_d = bpp_i;
        rem_d     = RW'(pix_per_word(bpp_i, DATA_W) - 1);
        have_pix  = 1'b1;
      end
      if (have_pix) begin
        pix_d   = PIX_W'(top_pixel(word, bits_sel)) & {PIX_W{video_enabled_i}};
        shreg_d = word << bpp_bits(bits_sel);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      run_q      <= 1'b0;
      de_sr_q    <= '0;
      pix_de_q   <= 1'b0;
      div_q      <= '0;
      shreg_q    <= '0;
      rem_q      <= '0;
      bpp_lat_q  <= '0;
      pix_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      de_sr_q[0] <= display_enable_i;
      for (int i = 1; i < DE_DELAY; i++) de_sr_q[i] <= de_sr_q[i-1];
      pix_de_q   <= de_d;
      div_q      <= div_d;
      shreg_q    <= shreg_d;
      rem_q      <= rem_d;
      bpp_lat_q  <= bpp_lat_d;
      pix_q      <= pix_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
